// File: rtl/control_sequencer.sv
// Hard-wired control unit for the single-bus datapath: fetch T0-T2, per-opcode execute T3-T7.
// Optional CU_SINGLE_STEP_EN adds a Step input and a WAIT_STEP state between instructions.
module control_sequencer #(
    parameter int unsigned      OPC_W   = 5,
    parameter logic [OPC_W-1:0] ADD_OPC = 5'b00011
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic [31:0]      IR,
    input  logic             CON_FF,
    input  logic             Stop,
`ifdef CU_SINGLE_STEP_EN
    input  logic             Step,
`endif
    output logic             Read,
    output logic             Write,
    output logic             IncPC,
    output logic [OPC_W-1:0] opcode,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             HIin,
    output logic             LOin,
    output logic             Yin,
    output logic             Zin,
    output logic             PCin,
    output logic             IRin,
    output logic             MARin,
    output logic             MDRin,
    output logic             Inportin,
    output logic             Outportin,
    output logic             CONin,
    output logic             HIout,
    output logic             LOout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             PCout,
    output logic             MDRout,
    output logic             Inportout,
    output logic             Cout,
    output logic             Run,
    output logic             instr_done,
    output logic             illegal
);

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALTED, STOPPED
`ifdef CU_SINGLE_STEP_EN
        , WAIT_STEP
`endif
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
    } cls_t;

    state_t           state_q, state_d, fin_state;
    cls_t             cls;
    logic             last;
    logic [OPC_W-1:0] op;
    logic             unused_ir_bits;

    assign op             = IR[31 -: OPC_W];
    assign unused_ir_bits = ^IR[31-OPC_W:0];

`ifdef CU_SINGLE_STEP_EN
    logic step_q, step_prev_q, step_rise;
    assign step_rise = step_q & ~step_prev_q;
`endif

    always_comb begin
        case (op) inside
            5'd0:           cls = C_LD;
            5'd1:           cls = C_LDI;
            5'd2:           cls = C_ST;
            [5'd3:5'd10]:   cls = C_ALU3;
            [5'd11:5'd13]:  cls = C_IMM;
            5'd14, 5'd15:   cls = C_MULDIV;
            5'd16, 5'd17:   cls = C_NEGNOT;
            5'd18:          cls = C_BR;
            5'd19:          cls = C_JR;
            5'd21:          cls = C_IN;
            5'd22:          cls = C_OUT;
            5'd23:          cls = C_MFHI;
            5'd24:          cls = C_MFLO;
            5'd25:          cls = C_NOP;
            5'd26:          cls = C_HALT;
            default:        cls = C_ILL;
        endcase
    end

    always_comb begin
        case (state_q)
            T3:      last = cls inside {C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL};
            T4:      last = (cls == C_NEGNOT);
            T5:      last = cls inside {C_ALU3, C_IMM, C_LDI};
            T6:      last = cls inside {C_MULDIV, C_BR};
            T7:      last = 1'b1;
            default: last = 1'b0;
        endcase
        // Halt beats Stop; Stop beats single-step waiting.
        if (cls == C_HALT)  fin_state = HALTED;
        else if (Stop)      fin_state = STOPPED;
        else
`ifdef CU_SINGLE_STEP_EN
                            fin_state = WAIT_STEP;
`else
                            fin_state = T0;
`endif
    end

    always_comb begin
        {Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin, Yin, Zin, PCin,
         IRin, MARin, MDRin, Inportin, Outportin, CONin, HIout, LOout, Zhighout, Zlowout,
         PCout, MDRout, Inportout, Cout, Run, illegal} = '0;
        opcode     = ADD_OPC;
        instr_done = last;
        state_d    = state_q;
        case (state_q)
            RST: begin opcode = '0; state_d = T0; end
            T0:  begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; state_d = T1; end
            T1:  begin
                Run = 1'b1; Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1;
                state_d = T2;
            end
            T2:  begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; state_d = T3; end
            T3: begin
                Run = 1'b1;
                case (cls)
                    C_ALU3:                    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_IMM, C_LDI, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_MULDIV:                  begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_NEGNOT: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
                    C_BR:     begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_JR:     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    C_IN:     begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_OUT:    begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; end
                    C_MFHI:   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_MFLO:   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ILL:    illegal = 1'b1;
                    default:  ;
                endcase
                state_d = last ? fin_state : T4;
            end
            T4: begin
                Run = 1'b1;
                case (cls)
                    C_ALU3:       begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
                    C_IMM:        begin Cout = 1'b1; Zin = 1'b1; opcode = op; end
                    C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; end
                    C_MULDIV:     begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
                    C_NEGNOT:     begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_BR:         begin PCout = 1'b1; Yin = 1'b1; end
                    default:      ;
                endcase
                state_d = last ? fin_state : T5;
            end
            T5: begin
                Run = 1'b1;
                case (cls)
                    C_ALU3, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_LD, C_ST:           begin Zlowout = 1'b1; MARin = 1'b1; end
                    C_MULDIV:             begin Zlowout = 1'b1; LOin = 1'b1; end
                    C_BR:                 begin Cout = 1'b1; Zin = 1'b1; end
                    default:              ;
                endcase
                state_d = last ? fin_state : T6;
            end
            T6: begin
                Run = 1'b1;
                case (cls)
                    C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                    C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    C_BR:     begin Zlowout = CON_FF; PCin = CON_FF; end
                    default:  ;
                endcase
                state_d = last ? fin_state : T7;
            end
            T7: begin
                Run = 1'b1;
                case (cls)
                    C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST:    Write = 1'b1;
                    default: ;
                endcase
                state_d = fin_state;
            end
            HALTED:  ;
            STOPPED: if (!Stop) state_d = T0;
`ifdef CU_SINGLE_STEP_EN
            WAIT_STEP: if (step_rise) state_d = T0;
`endif
            default: state_d = RST;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q     <= RST;
`ifdef CU_SINGLE_STEP_EN
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
`ifdef CU_SINGLE_STEP_EN
            step_q      <= Step;
            step_prev_q <= step_q;
`endif
        end
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hard-wired control unit for the single-bus datapath. It walks the datapath through fetch (T0-T2) and per-opcode execute steps (T3-T7), and drives every datapath control strobe. It replaces the hand-sequenced stimulus currently applied to the datapath.

Parameters:
OPC_W, 5, opcode field width; opcode is IR[31:27].
ADD_OPC, 5'b00011, ALU opcode driven during address and PC-offset adds.

Ports:
Clock  in  1  system clock, rising edge.
clear  in  1  asynchronous, active-low reset.
IR  in  32  instruction register contents from the datapath.
CON_FF  in  1  branch condition flag from the datapath.
Stop  in  1  pause request, sampled only at instruction boundary.
Read, Write, IncPC  out  1 each  memory and PC strobes.
opcode  out  5  ALU operation.
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select strobes.
HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin  out  1 each  register load enables.
HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout  out  1 each  bus drive enables.
Run  out  1  high while executing; low when halted or stopped.
instr_done  out  1  one-cycle pulse in the final step of each instruction.
illegal  out  1  one-cycle pulse in T3 for an undefined opcode.

Behaviour:
- State register: RST, T0..T7, HALTED, STOPPED (plus WAIT_STEP when the optional feature is compiled in). State changes on the rising Clock edge.
- Outputs are a combinational decode of state, IR[31:27] and CON_FF. At most one bus driver is active in any cycle.
- clear low: state goes to RST immediately. Every output is 0, including Run.
- RST: the first edge after clear releases moves to T0.
- opcode output: IR[31:27] during ALU steps; ADD_OPC otherwise.
- Fetch:
  T0 PCout, MARin.
  T1 Read, MDRin, PCin, IncPC.
  T2 MDRout, IRin.
- Execute (the final step asserts instr_done and returns to T0):
  add/sub/shr/shl/ror/rol/and/or (00011-01010): T3 Grb Rout Yin; T4 Grc Rout Zin; T5 Zlowout Gra Rin.
  addi/andi/ori (01011-01101), ldi (00001): T3 Grb BAout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
  ld (00000): same T3-T4 as ldi; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  st (00010): same T3-T5 as ld; T6 Gra Rout MDRin with Read=0; T7 Write.
  mul/div (01110/01111): T3 Gra Rout Yin; T4 Grb Rout Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  neg/not (10000/10001): T3 Grb Rout Zin; T4 Zlowout Gra Rin.
  br (10010): T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 Zlowout PCin if CON_FF=1, else no strobes. T6 is the final step either way.
  jr (10011): T3 Gra Rout PCin.
  in (10101): T3 Inportout Gra Rin.
  out (10110): T3 Gra Rout Outportin.
  mfhi/mflo (10111/11000): T3 HIout/LOout Gra Rin.
  nop (11001): T3, no strobes.
  halt (11010): T3 then HALTED. HALTED is left only by clear. Run=0 in HALTED.
  Any other opcode (including 10100, 11011-11111): treated as nop and illegal pulses in T3.
- Stop: sampled only on the final step's edge. If Stop=1, go to STOPPED instead of T0. STOPPED goes to T0 on the first edge where Stop=0. Stop has no effect mid-instruction.
- CON_FF is used only in br T6. IR is assumed stable from T3 to the end of the instruction.

Optional Feature:
CU_SINGLE_STEP_EN:
- Compiled in: adds input Step. After each instruction's final step, the FSM enters WAIT_STEP with Run=0 and no strobes. A rising edge of Step, registered and edge-detected internally, moves it to T0. Stop takes priority over WAIT_STEP.
- Compiled out: no Step port and no WAIT_STEP state; instructions run back-to-back.

Test Plan:
- Reset: pulse clear low mid-T4 of an add -> all outputs 0 immediately; T0 with PCout=MARin=1 one edge after release.
- add, IR=0x18918000 -> T3 Grb Rout Yin, T4 Grc Rout Zin with opcode=00011, T5 Zlowout Gra Rin, instr_done=1 in T5; next cycle T0.
- brzr, IR=0x91000023: CON_FF=1 -> T6 Zlowout PCin and opcode=00011 in T5; CON_FF=0 -> T6 no strobes. Both return to T0.
- ld, IR=0x00800065 -> T5 MARin, T6 Read MDRin, T7 MDRout Gra Rin; 8 cycles total.
- halt, IR=0xD0000000 -> HALTED, Run=0, no strobes for 20 cycles; clear restarts at T0. IR=0xF8000000 -> illegal pulse in T3, then T0.
- Stop=1 asserted during T4 of mul -> mul completes T6 (HIin), enters STOPPED, Run=0; Stop=0 -> T0 next edge.
